// File: rtl/pump_pkg.sv
// pump_pkg: shared types for the tank pump controller.
// Holds the per-channel FSM state encoding, the debounced sensor-pair decode
// and the helper that maps a (low, high) sensor pair onto that decode.
package pump_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EMPTY,
        MID,
        FULL,
        INVALID
    } level_t;

    // A high mark without the low mark is physically impossible: wiring or float fault.
    function automatic level_t decode_level(input logic low, input logic high);
        case ({low, high})
            2'b00:   return EMPTY;
            2'b10:   return MID;
            2'b11:   return FULL;
            default: return INVALID;
        endcase
    endfunction

endpackage

// File: rtl/pump_level_ctrl_if.sv
// pump_level_ctrl_if: per-station sensor inputs and pump driver outputs.
// The master side (sensor pins / host) drives the levels and permits.
// The slave side (the controller) drives the pump and fault outputs.
interface pump_level_ctrl_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] low;
    logic [N_CH-1:0] high;
    logic [N_CH-1:0] enable;
    logic [N_CH-1:0] clr_fault;
    logic [N_CH-1:0] pump_on;
    logic [N_CH-1:0] pump_clk;
    logic [N_CH-1:0] fault;

    modport master (
        output low, high, enable, clr_fault,
        input  pump_on, pump_clk, fault
    );

    modport slave (
        input  low, high, enable, clr_fault,
        output pump_on, pump_clk, fault
    );
endinterface

// File: rtl/pump_chan.sv
// pump_chan: one tank/pump channel.
// Sensor synchronizer and debouncer, IDLE/FILL/FAULT hysteresis FSM,
// pump clock divider and, with PUMP_TIMEOUT_EN defined, a fill timeout
// that counts pump_clk rising edges.
module pump_chan
    import pump_pkg::*;
#(
    parameter int DEB_LEN        = 8,
    parameter int HALF_PERIOD    = 25000,
    parameter int TIMEOUT_PULSES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic low,
    input  logic high,
    input  logic enable,
    input  logic clr_fault,
    output logic pump_on,
    output logic pump_clk,
    output logic fault
);

    localparam int DCW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam int HCW = $clog2(HALF_PERIOD);

    // Bit 0 carries the low sensor, bit 1 the high sensor.
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     deb_q;
    logic [DCW-1:0] deb_cnt_q [2];
    level_t         level;
    state_t         state_q, state_d;
    logic           fill_run;
    logic           half_wrap;
    logic [HCW-1:0] half_cnt_q;
    logic           pump_clk_q;
    logic           timeout;

    // Two-stage synchronizer; resets to "full" so nothing pumps until empty is seen.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {high, low};
            sync2_q <= sync1_q;
        end
    end

    // Debounce each bit: accept a new value after DEB_LEN consecutive differing samples.
    // NOTE: this array holds control state, not data storage, so every element is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= 2'b11;
            for (int b = 0; b < 2; b++) deb_cnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == deb_q[b]) begin
                    deb_cnt_q[b] <= '0;
                end else if (deb_cnt_q[b] == DCW'(DEB_LEN - 1)) begin
                    deb_q[b]     <= sync2_q[b];
                    deb_cnt_q[b] <= '0;
                end else begin
                    deb_cnt_q[b] <= deb_cnt_q[b] + DCW'(1);
                end
            end
        end
    end

    assign level = decode_level(deb_q[0], deb_q[1]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; in FILL invalid beats timeout beats enable drop beats full.
    // NOTE: state_d is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (level == INVALID)                  state_d = FAULT;
                else if (enable && (level == EMPTY))   state_d = FILL;
            end
            FILL: begin
                if ((level == INVALID) || timeout)     state_d = FAULT;
                else if (!enable || (level == FULL))   state_d = IDLE;
            end
            FAULT: begin
                if (clr_fault && (level != INVALID))   state_d = IDLE;
            end
            default:                                   state_d = IDLE;
        endcase
    end

    // Divider runs only on edges where the channel stays in FILL; entry and exit clear it,
    // so pump_clk drops together with pump_on and restarts from a full half period.
    assign fill_run  = (state_q == FILL) && (state_d == FILL);
    assign half_wrap = (half_cnt_q == HCW'(HALF_PERIOD - 1));

    // Pump clock divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt_q <= '0;
            pump_clk_q <= 1'b0;
        end else if (fill_run) begin
            if (half_wrap) begin
                half_cnt_q <= '0;
                pump_clk_q <= ~pump_clk_q;
            end else begin
                half_cnt_q <= half_cnt_q + HCW'(1);
            end
        end else begin
            half_cnt_q <= '0;
            pump_clk_q <= 1'b0;
        end
    end

`ifdef PUMP_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_PULSES + 1);

    logic [TCW-1:0] tmo_cnt_q;

    // Count pump_clk rising edges within one fill; the limit is seen on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             tmo_cnt_q <= '0;
        else if (!fill_run)                     tmo_cnt_q <= '0;
        else if (half_wrap && !pump_clk_q)      tmo_cnt_q <= tmo_cnt_q + TCW'(1);
    end

    assign timeout = (tmo_cnt_q == TCW'(TIMEOUT_PULSES));
`else
    assign timeout = 1'b0;
`endif

    assign pump_on  = (state_q == FILL);
    assign fault    = (state_q == FAULT);
    assign pump_clk = pump_clk_q;

endmodule

// File: rtl/pump_level_ctrl.sv
// pump_level_ctrl: multi-channel tank pump controller, one per pump station.
// Instantiates N_CH independent pump_chan channels on the station interface.
// Optional build macro: PUMP_TIMEOUT_EN adds a per-fill pump_clk edge timeout.
module pump_level_ctrl
    import pump_pkg::*;
#(
    parameter int N_CH           = 2,
    parameter int DEB_LEN        = 8,
    parameter int HALF_PERIOD    = 25000,
    parameter int TIMEOUT_PULSES = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pump_level_ctrl_if.slave     bus
);

    logic [N_CH-1:0] pump_on_v;
    logic [N_CH-1:0] pump_clk_v;
    logic [N_CH-1:0] fault_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        pump_chan #(
            .DEB_LEN        (DEB_LEN),
            .HALF_PERIOD    (HALF_PERIOD),
            .TIMEOUT_PULSES (TIMEOUT_PULSES)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .low       (bus.low[i]),
            .high      (bus.high[i]),
            .enable    (bus.enable[i]),
            .clr_fault (bus.clr_fault[i]),
            .pump_on   (pump_on_v[i]),
            .pump_clk  (pump_clk_v[i]),
            .fault     (fault_v[i])
        );
    end

    assign bus.pump_on  = pump_on_v;
    assign bus.pump_clk = pump_clk_v;
    assign bus.fault    = fault_v;

endmodule

// File: tb/tb_pump_level_ctrl.sv
// tb_pump_level_ctrl: self-checking bench for pump_level_ctrl.
// Directed vector table, hand-written corner sequences and randomized
// stimulus, all compared every cycle against a behavioural reference model.
// Honours PUMP_TIMEOUT_EN the same way the design does.
module tb_pump_level_ctrl;

    localparam int N_CH = 2;
    localparam int DEB  = 4;
    localparam int HP   = 3;
    localparam int TP   = 5;
    localparam int HL   = DEB + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pump_level_ctrl_if #(.N_CH(N_CH)) bus ();

    pump_level_ctrl #(
        .N_CH           (N_CH),
        .DEB_LEN        (DEB),
        .HALF_PERIOD    (HP),
        .TIMEOUT_PULSES (TP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounced bit flips when the last DEB synchronized samples (raw delayed by two
    // edges) all disagree with it; pump_clk is derived from edges elapsed since entry.
    typedef enum int {M_IDLE, M_FILL, M_FAULT} m_state_e;

    m_state_e m_st [N_CH];
    int       m_k  [N_CH];
    bit       m_dl [N_CH];
    bit       m_dh [N_CH];
    bit       m_hl [N_CH][HL];
    bit       m_hh [N_CH][HL];

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_st[c] = M_IDLE;
            m_k[c]  = 0;
            m_dl[c] = 1'b1;
            m_dh[c] = 1'b1;
            for (int j = 0; j < HL; j++) begin
                m_hl[c][j] = 1'b1;
                m_hh[c][j] = 1'b1;
            end
        end
    endfunction

    function automatic bit settled_flip(input bit cur, input bit hist [HL]);
        for (int j = 2; j < HL; j++) if (hist[j] == cur) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < N_CH; c++) begin
            bit       empty, full, invalid, tmo;
            m_state_e nst;
            empty   = !m_dl[c] && !m_dh[c];
            full    =  m_dl[c] &&  m_dh[c];
            invalid = !m_dl[c] &&  m_dh[c];
            tmo     = 1'b0;
`ifdef PUMP_TIMEOUT_EN
            tmo = (m_st[c] == M_FILL) && (m_k[c] == (2 * TP - 1) * HP);
`endif
            nst = m_st[c];
            case (m_st[c])
                M_IDLE:  if (invalid) nst = M_FAULT;
                         else if (bus.enable[c] && empty) nst = M_FILL;
                M_FILL:  if (invalid || tmo) nst = M_FAULT;
                         else if (!bus.enable[c] || full) nst = M_IDLE;
                default: if (bus.clr_fault[c] && !invalid) nst = M_IDLE;
            endcase
            m_k[c]  = (m_st[c] == M_FILL && nst == M_FILL) ? m_k[c] + 1 : 0;
            m_st[c] = nst;
            for (int j = HL - 1; j > 0; j--) begin
                m_hl[c][j] = m_hl[c][j-1];
                m_hh[c][j] = m_hh[c][j-1];
            end
            m_hl[c][0] = bus.low[c];
            m_hh[c][0] = bus.high[c];
            if (settled_flip(m_dl[c], m_hl[c])) m_dl[c] = !m_dl[c];
            if (settled_flip(m_dh[c], m_hh[c])) m_dh[c] = !m_dh[c];
        end
    endfunction

    function automatic bit m_on(input int c);
        return m_st[c] == M_FILL;
    endfunction
    function automatic bit m_clk(input int c);
        return (m_st[c] == M_FILL) && (((m_k[c] / HP) % 2) == 1);
    endfunction
    function automatic bit m_flt(input int c);
        return m_st[c] == M_FAULT;
    endfunction

    // Advance n clocks; outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            for (int c = 0; c < N_CH; c++) begin
                check($sformatf("model ch%0d pump_on", c),  bus.pump_on[c],  m_on(c));
                check($sformatf("model ch%0d pump_clk", c), bus.pump_clk[c], m_clk(c));
                check($sformatf("model ch%0d fault", c),    bus.fault[c],    m_flt(c));
            end
        end
    endtask

    // ---------------- directed vector table (channel 0) ----------------
    typedef struct {
        bit l, h, e, c;
        int n;
        bit on, pclk, flt;
    } vec_t;

    vec_t vecs [$];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int rises, cyc, hold [N_CH];
        bit prev;

        //                l  h  e  c   n  on clk flt
        vecs.push_back('{0, 0, 1, 0,  6, 0, 0, 0});  // debounce in progress
        vecs.push_back('{0, 0, 1, 0,  1, 1, 0, 0});  // FILL at 3+DEB
        vecs.push_back('{0, 0, 1, 0,  2, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 0,  1, 1, 1, 0});  // first rise HP after pump_on
        vecs.push_back('{0, 0, 1, 0,  3, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 0,  3, 1, 1, 0});  // period 2*HP
        vecs.push_back('{1, 0, 1, 0, 12, 1, 1, 0});  // mid holds FILL
        vecs.push_back('{1, 1, 1, 0,  6, 1, 1, 0});  // full not yet acted on
        vecs.push_back('{1, 1, 1, 0,  1, 0, 0, 0});  // pump_clk forced low on exit
        vecs.push_back('{0, 0, 1, 0,  7, 1, 0, 0});  // refill
        vecs.push_back('{1, 0, 1, 0, 10, 1, 1, 0});
        vecs.push_back('{1, 1, 1, 0,  3, 1, 0, 0});  // 3-cycle glitch on high
        vecs.push_back('{1, 0, 1, 0, 10, 1, 1, 0});  // glitch rejected
        vecs.push_back('{1, 1, 1, 0,  4, 1, 1, 0});  // 4-cycle pulse
        vecs.push_back('{1, 0, 1, 0,  3, 0, 0, 0});  // pulse accepted, FILL -> IDLE
        vecs.push_back('{1, 0, 1, 0,  8, 0, 0, 0});  // mid holds IDLE
        vecs.push_back('{0, 1, 1, 0,  6, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 0,  1, 0, 0, 1});  // invalid -> FAULT
        vecs.push_back('{0, 1, 1, 1,  3, 0, 0, 1});  // clear refused while invalid
        vecs.push_back('{1, 1, 1, 0, 10, 0, 0, 1});  // still latched
        vecs.push_back('{1, 1, 1, 1,  1, 0, 0, 0});  // clear accepted next cycle
        vecs.push_back('{1, 1, 1, 0,  2, 0, 0, 0});

        bus.low       = '1;
        bus.high      = '1;
        bus.enable    = '0;
        bus.clr_fault = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset pump_on",  bus.pump_on,  0);
        check("reset pump_clk", bus.pump_clk, 0);
        check("reset fault",    bus.fault,    0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.low[0]       = vecs[i].l;
            bus.high[0]      = vecs[i].h;
            bus.enable[0]    = vecs[i].e;
            bus.clr_fault[0] = vecs[i].c;
            step(vecs[i].n);
            check($sformatf("vec%0d pump_on", i),  bus.pump_on[0],  vecs[i].on);
            check($sformatf("vec%0d pump_clk", i), bus.pump_clk[0], vecs[i].pclk);
            check($sformatf("vec%0d fault", i),    bus.fault[0],    vecs[i].flt);
            check($sformatf("vec%0d ch1 idle", i), {bus.pump_on[1], bus.fault[1]}, 0);
        end

        // Enable drop mid-fill, then re-enable while still empty.
        bus.low[0]  = 1'b0;
        bus.high[0] = 1'b0;
        step(7);
        check("en seq pump_on", bus.pump_on[0], 1);
        step(4);
        check("en seq pump_clk high", bus.pump_clk[0], 1);
        bus.enable[0] = 1'b0;
        step(1);
        check("en drop pump_on", bus.pump_on[0], 0);
        check("en drop pump_clk", bus.pump_clk[0], 0);
        bus.enable[0] = 1'b1;
        step(1);
        check("re-enable pump_on", bus.pump_on[0], 1);
        step(2);
        check("re-enable clk low", bus.pump_clk[0], 0);
        step(1);
        check("re-enable clk rise", bus.pump_clk[0], 1);

        // Asynchronous reset mid-fill drops outputs without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst pump_on", bus.pump_on[0], 0);
        check("async rst pump_clk", bus.pump_clk[0], 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Refill after reset must wait for empty to be confirmed again.
        cyc = 0;
        for (int i = 0; i < 20 && !bus.pump_on[0]; i++) begin
            step(1);
            cyc++;
        end
        check("refill latency", cyc, 3 + DEB);

        rises = 0;
        prev  = 1'b0;
`ifdef PUMP_TIMEOUT_EN
        for (int i = 0; i < 200 && rises < TP; i++) begin
            step(1);
            if (bus.pump_clk[0] && !prev) rises++;
            prev = bus.pump_clk[0];
        end
        check("timeout rises seen", rises, TP);
        check("no fault at last rise", bus.fault[0], 0);
        step(1);
        check("timeout fault", bus.fault[0], 1);
        check("timeout pump_on", bus.pump_on[0], 0);
        check("timeout pump_clk", bus.pump_clk[0], 0);
`else
        for (int i = 0; i < 300 && rises < 21; i++) begin
            step(1);
            if (bus.pump_clk[0] && !prev) rises++;
            prev = bus.pump_clk[0];
        end
        check("no-timeout rises seen", rises, 21);
        check("no-timeout pump_on", bus.pump_on[0], 1);
        check("no-timeout fault", bus.fault[0], 0);
`endif

        // Randomized traffic on both channels, including sub-DEB glitches.
        bus.enable    = '1;
        bus.clr_fault = '0;
        for (int c = 0; c < N_CH; c++) hold[c] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (hold[c] == 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    bus.low[c]  = (r >= 4) && (r <= 8);
                    bus.high[c] = (r >= 6);
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60)
                                                          : $urandom_range(1, 8);
                end
                hold[c]--;
                if ($urandom_range(0, 39) == 0) bus.enable[c] = ~bus.enable[c];
                bus.clr_fault[c] = ($urandom_range(0, 9) == 0);
            end
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
